controlador_ula_multibyte: RTL and testbench

- Sequencer that runs multi-byte operations on the shared 8-bit ULA, one byte per clock, LSB first.
- Arithmetic operations chain the carry between bytes; the block merges the per-byte flags into word-level flags.
- Sits between a requester (valid/ready) and the combinational ULA instance.
- Both this block and the ULA are instantiated side by side in the top-level wrapper.

---
 rtl/ula_pkg.sv | 27 ++
 rtl/controlador_ula_multibyte_if.sv | 65 ++++++
 rtl/controlador_ula_multibyte.sv | 142 ++++++++++++++
 tb/tb_controlador_ula_multibyte.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the multi-byte ULA sequencer: opcodes, flag bit
// positions, FSM state encoding and the arithmetic-opcode classifier.
package ula_pkg;

    localparam int unsigned LARG_BYTE  = 8;
    localparam int unsigned LARG_OP    = 3;
    localparam int unsigned LARG_FLAGS = 3;

    localparam logic [LARG_OP-1:0] OP_SOMA = 3'b000;
    localparam logic [LARG_OP-1:0] OP_SUB  = 3'b001;

    localparam int unsigned FLAG_CARRY = 0;
    localparam int unsigned FLAG_ZERO  = 1;
    localparam int unsigned FLAG_OVF   = 2;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        EXECUTA   = 2'd1,
        RESULTADO = 2'd2
    } estado_t;

    // Only add/subtract propagate the carry from one byte slice to the next.
    function automatic logic eh_aritmetica(input logic [LARG_OP-1:0] opcode);
        return (opcode == OP_SOMA) || (opcode == OP_SUB);
    endfunction

endpackage

// File: rtl/controlador_ula_multibyte_if.sv
// Request, ULA-side and result signals of the multi-byte ULA sequencer.
// master: the sequencer itself; slave: requester/consumer/ULA environment.
interface controlador_ula_multibyte_if #(
    parameter int unsigned N_BYTES = 2
);
    localparam int unsigned LARG_PALAVRA = ula_pkg::LARG_BYTE * N_BYTES;

    logic                            Req_valid_in;
    logic                            Req_ready_out;
    logic [LARG_PALAVRA-1:0]         A_in;
    logic [LARG_PALAVRA-1:0]         B_in;
    logic                            C_in;
    logic [ula_pkg::LARG_OP-1:0]     Operacao_in;

    logic [ula_pkg::LARG_BYTE-1:0]   Ula_A_out;
    logic [ula_pkg::LARG_BYTE-1:0]   Ula_B_out;
    logic                            Ula_C_out;
    logic [ula_pkg::LARG_OP-1:0]     Ula_Operacao_out;
    logic [ula_pkg::LARG_BYTE-1:0]   Ula_Saida_in;
    logic [ula_pkg::LARG_FLAGS-1:0]  Ula_Flags_in;

    logic                            Res_valid_out;
    logic                            Res_ready_in;
    logic [LARG_PALAVRA-1:0]         Saida_out;
    logic [ula_pkg::LARG_FLAGS-1:0]  Flags_out;

    modport master (
        input  Req_valid_in,
        output Req_ready_out,
        input  A_in,
        input  B_in,
        input  C_in,
        input  Operacao_in,
        output Ula_A_out,
        output Ula_B_out,
        output Ula_C_out,
        output Ula_Operacao_out,
        input  Ula_Saida_in,
        input  Ula_Flags_in,
        output Res_valid_out,
        input  Res_ready_in,
        output Saida_out,
        output Flags_out
    );

    modport slave (
        output Req_valid_in,
        input  Req_ready_out,
        output A_in,
        output B_in,
        output C_in,
        output Operacao_in,
        input  Ula_A_out,
        input  Ula_B_out,
        input  Ula_C_out,
        input  Ula_Operacao_out,
        output Ula_Saida_in,
        output Ula_Flags_in,
        input  Res_valid_out,
        output Res_ready_in,
        input  Saida_out,
        input  Flags_out
    );

endinterface

// File: rtl/controlador_ula_multibyte.sv
// Multi-byte sequencer for the shared 8-bit ULA: feeds one byte slice per
// clock (LSB first), chains the carry for add/sub, merges per-byte flags
// into word flags and returns the word through a valid/ready handshake.
// Optional completed-operation counter: define ULA_CONTADOR_OPS_EN.
module controlador_ula_multibyte
    import ula_pkg::*;
#(
    parameter int unsigned N_BYTES = 2
`ifdef ULA_CONTADOR_OPS_EN
    ,
    parameter int unsigned LARG_CONT = 16
`endif
) (
    input  logic                      Clock_in,
    input  logic                      Reset_in,
    controlador_ula_multibyte_if.master bus
`ifdef ULA_CONTADOR_OPS_EN
    ,
    output logic [LARG_CONT-1:0]      Contador_ops_out
`endif
);

    localparam int unsigned LARG_IDX = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [LARG_IDX-1:0] IDX_ULTIMO = LARG_IDX'(N_BYTES - 1);

    estado_t                                 estado;
    estado_t                                 prox_estado;
    logic [LARG_IDX-1:0]                     idx;
    logic [N_BYTES-1:0][LARG_BYTE-1:0]       a_reg;
    logic [N_BYTES-1:0][LARG_BYTE-1:0]       b_reg;
    logic                                    c_reg;
    logic [LARG_OP-1:0]                      op_reg;
    logic                                    carry_reg;
    logic                                    zero_acc;
    logic [N_BYTES-1:0][LARG_BYTE-1:0]       res_reg;
    logic [LARG_FLAGS-1:0]                   flags_reg;

    logic aceita;
    logic ultimo;
    logic entrega;

    assign aceita  = bus.Req_valid_in && (estado == OCIOSO);
    assign ultimo  = (estado == EXECUTA) && (idx == IDX_ULTIMO);
    assign entrega = (estado == RESULTADO) && bus.Res_ready_in;

    // State register
    always_ff @(posedge Clock_in) begin
        if (Reset_in) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    // Next-state logic
    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:    if (aceita)  prox_estado = EXECUTA;
            EXECUTA:   if (ultimo)  prox_estado = RESULTADO;
            RESULTADO: if (entrega) prox_estado = OCIOSO;
            default:   prox_estado = OCIOSO;
        endcase
    end

    // Outputs decoded from state and the registered operation
    always_comb begin
        bus.Req_ready_out    = 1'b0;
        bus.Ula_A_out        = '0;
        bus.Ula_B_out        = '0;
        bus.Ula_C_out        = 1'b0;
        bus.Ula_Operacao_out = '0;
        bus.Res_valid_out    = 1'b0;
        case (estado)
            OCIOSO: begin
                bus.Req_ready_out = 1'b1;
            end
            EXECUTA: begin
                bus.Ula_A_out        = a_reg[idx];
                bus.Ula_B_out        = b_reg[idx];
                bus.Ula_Operacao_out = op_reg;
                bus.Ula_C_out        = ((idx != '0) && eh_aritmetica(op_reg)) ? carry_reg : c_reg;
            end
            RESULTADO: begin
                bus.Res_valid_out = 1'b1;
            end
            default: begin
                bus.Req_ready_out = 1'b0;
            end
        endcase
    end

    // Operand capture, byte sequencing and flag accumulation
    always_ff @(posedge Clock_in) begin
        if (Reset_in) begin
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            c_reg     <= 1'b0;
            op_reg    <= '0;
            carry_reg <= 1'b0;
            zero_acc  <= 1'b0;
            res_reg   <= '0;
            flags_reg <= '0;
        end else if (aceita) begin
            idx       <= '0;
            a_reg     <= bus.A_in;
            b_reg     <= bus.B_in;
            c_reg     <= bus.C_in;
            op_reg    <= bus.Operacao_in;
            carry_reg <= 1'b0;
            zero_acc  <= 1'b1;
        end else if (estado == EXECUTA) begin
            res_reg[idx] <= bus.Ula_Saida_in;
            carry_reg    <= bus.Ula_Flags_in[FLAG_CARRY];
            zero_acc     <= zero_acc & bus.Ula_Flags_in[FLAG_ZERO];
            if (ultimo) begin
                idx                  <= '0;
                flags_reg[FLAG_CARRY] <= bus.Ula_Flags_in[FLAG_CARRY];
                flags_reg[FLAG_ZERO]  <= zero_acc & bus.Ula_Flags_in[FLAG_ZERO];
                flags_reg[FLAG_OVF]   <= bus.Ula_Flags_in[FLAG_OVF];
            end else begin
                idx <= idx + LARG_IDX'(1);
            end
        end
    end

    assign bus.Saida_out = res_reg;
    assign bus.Flags_out = flags_reg;

`ifdef ULA_CONTADOR_OPS_EN
    // Saturating count of delivered results
    always_ff @(posedge Clock_in) begin
        if (Reset_in) begin
            Contador_ops_out <= '0;
        end else if (entrega && (Contador_ops_out != '1)) begin
            Contador_ops_out <= Contador_ops_out + LARG_CONT'(1);
        end
    end
`endif

endmodule

// File: tb/tb_controlador_ula_multibyte.sv
// Bench for controlador_ula_multibyte: behavioural 8-bit ULA in the loop,
// directed vector table, word-level reference model for random operations,
// back-pressure and mid-operation reset sequences.
module tb_controlador_ula_multibyte;
    import ula_pkg::*;

    localparam int unsigned N = 2;
    localparam int unsigned W = 8 * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    controlador_ula_multibyte_if #(.N_BYTES(N)) bus_if ();

`ifdef ULA_CONTADOR_OPS_EN
    localparam int unsigned LC = 2;
    logic [LC-1:0] cont;
    controlador_ula_multibyte #(.N_BYTES(N), .LARG_CONT(LC)) dut (
        .Clock_in(clk), .Reset_in(rst), .bus(bus_if), .Contador_ops_out(cont)
    );
`else
    controlador_ula_multibyte #(.N_BYTES(N)) dut (
        .Clock_in(clk), .Reset_in(rst), .bus(bus_if)
    );
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int ops_done = 0;

    // Behavioural 8-bit ULA: returns {ovf, zero, carry, result}
    function automatic logic [10:0] ula(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic [2:0] op);
        logic [8:0] t;
        logic [7:0] s;
        logic cy, ov;
        cy = 1'b0; ov = 1'b0; s = a;
        case (op)
            3'b000: begin
                t = {1'b0, a} + {1'b0, b} + {8'b0, c};
                s = t[7:0]; cy = t[8];
                ov = (a[7] == b[7]) && (s[7] != a[7]);
            end
            3'b001: begin
                t = {1'b0, a} - {1'b0, b} - {8'b0, c};
                s = t[7:0]; cy = t[8];
                ov = (a[7] != b[7]) && (s[7] != a[7]);
            end
            3'b010: s = a & b;
            3'b011: s = a | b;
            3'b100: s = a ^ b;
            3'b101: begin
                t = {1'b0, a} + {1'b0, b} + {8'b0, c};
                s = t[7:0]; cy = t[8];
            end
            default: s = a;
        endcase
        return {ov, (s == 8'h00), cy, s};
    endfunction

    always_comb begin
        {bus_if.Ula_Flags_in, bus_if.Ula_Saida_in} =
            ula(bus_if.Ula_A_out, bus_if.Ula_B_out, bus_if.Ula_C_out, bus_if.Ula_Operacao_out);
    end

    // Word-level reference: returns {flags, result}
    function automatic logic [W+2:0] modelo(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic c);
        logic [W:0] t;
        logic [W-1:0] s;
        logic [8:0] tb8;
        logic cy, ov;
        cy = 1'b0; ov = 1'b0; s = a;
        case (op)
            3'b000: begin
                t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
                s = t[W-1:0]; cy = t[W];
                ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            3'b001: begin
                t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c};
                s = t[W-1:0]; cy = t[W];
                ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
            end
            3'b010: s = a & b;
            3'b011: s = a | b;
            3'b100: s = a ^ b;
            3'b101: begin
                for (int i = 0; i < int'(N); i++) begin
                    tb8 = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]} + {8'b0, c};
                    s[8*i +: 8] = tb8[7:0];
                    cy = tb8[8];
                end
            end
            default: s = a;
        endcase
        return {ov, (s == '0), cy, s};
    endfunction

    // Carry the ULA should see on byte i
    function automatic logic exp_cin(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic c, input int i);
        logic [W-1:0] m;
        logic [W:0] soma;
        if (i == 0 || op > 3'b001) return c;
        m = '0;
        for (int k = 0; k < 8 * i; k++) m[k] = 1'b1;
        if (op == 3'b000) begin
            soma = {1'b0, a & m} + {1'b0, b & m} + {{W{1'b0}}, c};
            return soma[8*i];
        end
        return ({1'b0, a & m} < ({1'b0, b & m} + {{W{1'b0}}, c}));
    endfunction

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic check_cont();
`ifdef ULA_CONTADOR_OPS_EN
        check("contador", 32'(cont), (ops_done > 3) ? 32'd3 : 32'(ops_done));
`endif
    endtask

    // Full transaction with byte-level probes, back-pressure and handshake
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input int hold,
                          input logic [W-1:0] exp_s, input logic [2:0] exp_f);
        logic [W-1:0] s_ini;
        logic [2:0]   f_ini;
        @(negedge clk);
        bus_if.Req_valid_in = 1'b1;
        bus_if.A_in = a; bus_if.B_in = b; bus_if.C_in = c; bus_if.Operacao_in = op;
        check("ready_idle", 32'(bus_if.Req_ready_out), 32'd1);
        @(posedge clk); #1;
        bus_if.Req_valid_in = 1'b0;
        bus_if.A_in = W'($urandom); bus_if.B_in = W'($urandom);
        bus_if.C_in = ~c; bus_if.Operacao_in = 3'($urandom);
        for (int i = 0; i < int'(N); i++) begin
            check("ula_a", 32'(bus_if.Ula_A_out), 32'(a[8*i +: 8]));
            check("ula_b", 32'(bus_if.Ula_B_out), 32'(b[8*i +: 8]));
            check("ula_op", 32'(bus_if.Ula_Operacao_out), 32'(op));
            check("ula_c", 32'(bus_if.Ula_C_out), 32'(exp_cin(op, a, b, c, i)));
            check("valid_early", 32'(bus_if.Res_valid_out), 32'd0);
            @(posedge clk); #1;
        end
        check("valid_latency", 32'(bus_if.Res_valid_out), 32'd1);
        check("saida", 32'(bus_if.Saida_out), 32'(exp_s));
        check("flags", 32'(bus_if.Flags_out), 32'(exp_f));
        s_ini = bus_if.Saida_out;
        f_ini = bus_if.Flags_out;
        bus_if.Req_valid_in = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(bus_if.Res_valid_out), 32'd1);
            check("hold_ready", 32'(bus_if.Req_ready_out), 32'd0);
            check("hold_saida", 32'(bus_if.Saida_out), 32'(s_ini));
            check("hold_flags", 32'(bus_if.Flags_out), 32'(f_ini));
        end
        bus_if.Req_valid_in = 1'b0;
        bus_if.Res_ready_in = 1'b1;
        @(posedge clk); #1;
        bus_if.Res_ready_in = 1'b0;
        ops_done++;
        check("post_valid", 32'(bus_if.Res_valid_out), 32'd0);
        check("post_ready", 32'(bus_if.Req_ready_out), 32'd1);
        check_cont();
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        int           hold;
        logic [W-1:0] s;
        logic [2:0]   f;
    } vetor_t;

    vetor_t tab[7];

    initial begin
        logic [W+2:0] ref_res;
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;
        logic         rc;

        tab[0] = '{3'b000, 16'h00FF, 16'h0001, 1'b0, 0, 16'h0100, 3'b000};
        tab[1] = '{3'b000, 16'hFFFF, 16'h0001, 1'b0, 1, 16'h0000, 3'b011};
        tab[2] = '{3'b010, 16'hF0F0, 16'hFFFF, 1'b1, 0, 16'hF0F0, 3'b000};
        tab[3] = '{3'b001, 16'h0000, 16'h0001, 1'b0, 5, 16'hFFFF, 3'b001};
        tab[4] = '{3'b000, 16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 3'b100};
        tab[5] = '{3'b101, 16'h00FF, 16'h0001, 1'b1, 2, 16'h0101, 3'b000};
        tab[6] = '{3'b001, 16'h1234, 16'h1234, 1'b0, 0, 16'h0000, 3'b010};

        rst = 1'b1;
        bus_if.Req_valid_in = 1'b0;
        bus_if.Res_ready_in = 1'b0;
        bus_if.A_in = '0; bus_if.B_in = '0; bus_if.C_in = 1'b0; bus_if.Operacao_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus_if.Res_valid_out), 32'd0);
        check("rst_ready", 32'(bus_if.Req_ready_out), 32'd1);
        check("rst_saida", 32'(bus_if.Saida_out), 32'd0);
        check("rst_flags", 32'(bus_if.Flags_out), 32'd0);
        check("rst_ula_a", 32'(bus_if.Ula_A_out), 32'd0);
        check("rst_ula_c", 32'(bus_if.Ula_C_out), 32'd0);
        rst = 1'b0;
        check_cont();

        for (int i = 0; i < 7; i++) begin
            run_op(tab[i].op, tab[i].a, tab[i].b, tab[i].c, tab[i].hold, tab[i].s, tab[i].f);
        end

        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom_range(0, 1));
            ref_res = modelo(rop, ra, rb, rc);
            run_op(rop, ra, rb, rc, int'($urandom_range(0, 3)), ref_res[W-1:0], ref_res[W+2:W]);
        end

        // Known nonzero result, then reset during byte 0 of the next operation
        run_op(3'b000, 16'h00FF, 16'h0001, 1'b0, 0, 16'h0100, 3'b000);
        @(negedge clk);
        bus_if.Req_valid_in = 1'b1;
        bus_if.A_in = 16'hFFFF; bus_if.B_in = 16'h0001; bus_if.C_in = 1'b1; bus_if.Operacao_in = 3'b000;
        @(posedge clk); #1;
        bus_if.Req_valid_in = 1'b0;
        check("mid_executa", 32'(bus_if.Ula_A_out), 32'h00FF);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ops_done = 0;
        check("mrst_ready", 32'(bus_if.Req_ready_out), 32'd1);
        check("mrst_valid", 32'(bus_if.Res_valid_out), 32'd0);
        check("mrst_saida", 32'(bus_if.Saida_out), 32'd0);
        check("mrst_flags", 32'(bus_if.Flags_out), 32'd0);
        check("mrst_ula_a", 32'(bus_if.Ula_A_out), 32'd0);
        check("mrst_ula_c", 32'(bus_if.Ula_C_out), 32'd0);
        check_cont();
        for (int k = 0; k < int'(N) + 3; k++) begin
            @(posedge clk); #1;
            check("mrst_no_result", 32'(bus_if.Res_valid_out), 32'd0);
        end

        for (int i = 0; i < 5; i++) begin
            run_op(tab[0].op, tab[0].a, tab[0].b, tab[0].c, 0, tab[0].s, tab[0].f);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
